// File: rtl/elevator_pkg.sv
// Shared types, constants and floor-mask helpers for the elevator controller.
// All location values are one-hot over NUM_FLOORS bits.
package elevator_pkg;

   localparam int NUM_FLOORS = 4;

   typedef enum logic [2:0] {
      S_INIT,
      S_IDLE,
      S_UP,
      S_DOWN,
      S_CHECK,
      S_DOOR
   } state_e;

   localparam logic [NUM_FLOORS-1:0] FLOOR0 = 4'b0001;
   localparam logic [NUM_FLOORS-1:0] FLOOR1 = 4'b0010;
   localparam logic [NUM_FLOORS-1:0] FLOOR2 = 4'b0100;
   localparam logic [NUM_FLOORS-1:0] FLOOR3 = 4'b1000;

   function automatic logic [NUM_FLOORS-1:0] below_mask(
      input logic [NUM_FLOORS-1:0] loc
   );
      return loc - 4'd1;
   endfunction

   function automatic logic [NUM_FLOORS-1:0] above_mask(
      input logic [NUM_FLOORS-1:0] loc
   );
      return ~(loc | below_mask(loc));
   endfunction

   function automatic logic is_onehot(
      input logic [NUM_FLOORS-1:0] loc
   );
      return (loc != 4'd0) && ((loc & below_mask(loc)) == 4'd0);
   endfunction

endpackage

// File: rtl/elevator_ctrl_timer.sv
// Loadable down-counter shared by travel and door timing.
// done is high whenever the count has reached zero.
module elev_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_start,
   input  logic [W-1:0] i_len,
   output logic         o_done
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (i_start) begin
         r_cnt <= i_len;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - W'(1);
      end
   end

   assign o_done = (r_cnt == '0);

endmodule

// File: rtl/elevator_ctrl.sv
// Elevator motion controller driving an external one-hot location register.
// Steps the car one floor per travel leg and services latched calls.
module elevator_ctrl
   import elevator_pkg::*;
#(
   parameter int TRAVEL_CYCLES = 8,
   parameter int DOOR_CYCLES   = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_FLOORS-1:0] req,
   input  logic [NUM_FLOORS-1:0] cur_loc,
   output logic [NUM_FLOORS-1:0] next_loc,
   output logic                  load,
   output logic                  moving_up,
   output logic                  moving_down,
   output logic                  door_open,
   output logic [NUM_FLOORS-1:0] pending,
   output logic                  loc_err
);

   localparam int MAXC = (TRAVEL_CYCLES > DOOR_CYCLES) ?
                         TRAVEL_CYCLES : DOOR_CYCLES;
   localparam int TW = $clog2(MAXC + 1);
   localparam logic [TW-1:0] TRV_LEN  = TW'(TRAVEL_CYCLES - 1);
   localparam logic [TW-1:0] DOOR_LEN = TW'(DOOR_CYCLES - 1);

   state_e                  r_state;
   state_e                  w_nstate;
   logic                    r_dir_up;
   logic [NUM_FLOORS-1:0]   r_pending;
   logic [NUM_FLOORS-1:0]   r_next_loc;
   logic [NUM_FLOORS-1:0]   w_nl;
   logic [NUM_FLOORS-1:0]   w_clr;
   logic                    w_loc_ok;
   logic                    w_here;
   logic                    w_up_req;
   logic                    w_dn_req;
   logic                    w_done;
   logic                    w_start;
   logic                    w_load;
   logic [TW-1:0]           w_len;

   function automatic state_e route(
      input logic here,
      input logic up,
      input logic dn,
      input logic dir_up
   );
      if (here) return S_DOOR;
      if (dir_up) begin
         if (up) return S_UP;
         if (dn) return S_DOWN;
      end else begin
         if (dn) return S_DOWN;
         if (up) return S_UP;
      end
      return S_IDLE;
   endfunction

   assign w_loc_ok = is_onehot(cur_loc);
   assign w_here   = |(r_pending & cur_loc);
   assign w_up_req = |(r_pending & above_mask(cur_loc));
   assign w_dn_req = |(r_pending & below_mask(cur_loc));

   always_comb begin
      w_nstate = r_state;
      w_load   = 1'b0;
      w_nl     = r_next_loc;
      unique case (r_state)
         S_INIT: begin
            w_load   = reset;
            w_nl     = FLOOR0;
            w_nstate = S_IDLE;
         end
         S_IDLE:
            w_nstate = route(w_here, w_up_req, w_dn_req, 1'b1);
         S_UP:
            if (w_done) begin
               w_load   = 1'b1;
               w_nl     = cur_loc << 1;
               w_nstate = S_CHECK;
            end
         S_DOWN:
            if (w_done) begin
               w_load   = 1'b1;
               w_nl     = cur_loc >> 1;
               w_nstate = S_CHECK;
            end
         S_CHECK:
            w_nstate = route(w_here, w_up_req, w_dn_req, r_dir_up);
         S_DOOR:
            if (w_done) begin
               w_nstate = route(w_here, w_up_req, w_dn_req, r_dir_up);
            end
         default:
            w_nstate = S_INIT;
      endcase
      // a corrupt location aborts whatever is in flight and re-parks the car
      if (r_state != S_INIT && !w_loc_ok) begin
         w_nstate = S_INIT;
         w_load   = 1'b0;
         w_nl     = r_next_loc;
      end
   end

   assign w_start = (w_nstate != r_state) &&
                    (w_nstate == S_UP || w_nstate == S_DOWN ||
                     w_nstate == S_DOOR);
   assign w_len   = (w_nstate == S_DOOR) ? DOOR_LEN : TRV_LEN;
   assign w_clr   = (w_loc_ok && (r_state == S_DOOR || w_nstate == S_DOOR)) ?
                    cur_loc : '0;

   elev_timer #(
      .W (TW)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .i_start (w_start),
      .i_len   (w_len),
      .o_done  (w_done)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= S_INIT;
         r_pending  <= '0;
         r_next_loc <= FLOOR0;
         r_dir_up   <= 1'b1;
      end else begin
         r_state    <= w_nstate;
         r_pending  <= (r_pending | req) & ~w_clr;
         r_next_loc <= w_nl;
         if (w_nstate == S_UP) begin
            r_dir_up <= 1'b1;
         end else if (w_nstate == S_DOWN) begin
            r_dir_up <= 1'b0;
         end else if (r_state == S_IDLE) begin
            r_dir_up <= 1'b1;
         end
      end
   end

   assign next_loc    = w_nl;
   assign load        = w_load;
   assign moving_up   = (r_state == S_UP);
   assign moving_down = (r_state == S_DOWN);
   assign door_open   = (r_state == S_DOOR);
   assign pending     = r_pending;
   assign loc_err     = (r_state != S_INIT) && !w_loc_ok;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed bench for elevator_ctrl with a floor-index reference model
// and a bench-side copy of the external location register.
module tb_elevator_ctrl;

   localparam int TRAVEL = 8;
   localparam int DOORC  = 16;

   localparam int M_INIT   = 0;
   localparam int M_IDLE   = 1;
   localparam int M_TRAVEL = 2;
   localparam int M_CHECK  = 3;
   localparam int M_DOOR   = 4;

   logic       clk;
   logic       reset;
   logic [3:0] req;
   logic [3:0] cur_loc;
   logic [3:0] next_loc;
   logic       load;
   logic       moving_up;
   logic       moving_down;
   logic       door_open;
   logic [3:0] pending;
   logic       loc_err;

   logic [3:0] r_q;
   logic       force_en;
   logic [3:0] force_val;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   bit         m_valid = 0;
   int         m_mode  = M_INIT;
   int         m_dir   = 1;
   int         m_left  = 0;
   logic [3:0] m_pend  = '0;
   logic [3:0] m_nl    = 4'b0001;

   // observation counters
   int         n_doors = 0;
   int         n_falls = 0;
   int         door_run = 0;
   int         last_door_len = 0;
   bit         prev_door = 0;
   logic [3:0] door_floor = '0;
   logic [3:0] load_log[$];

   elevator_ctrl #(
      .TRAVEL_CYCLES (TRAVEL),
      .DOOR_CYCLES   (DOORC)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .cur_loc     (cur_loc),
      .next_loc    (next_loc),
      .load        (load),
      .moving_up   (moving_up),
      .moving_down (moving_down),
      .door_open   (door_open),
      .pending     (pending),
      .loc_err     (loc_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_ff @(posedge clk) begin
      if (!reset) r_q <= '0;
      else if (load) r_q <= next_loc;
   end

   assign cur_loc = force_en ? force_val : r_q;

   task automatic chk(input string nm, input logic [3:0] act,
                      input logic [3:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_i(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic go(input int d);
      m_mode = M_TRAVEL;
      m_dir  = d;
      m_left = TRAVEL;
   endtask

   // pick the next move from the latched calls, preferring direction d
   task automatic decide(input int f, input int d);
      bit up, dn;
      up = 0;
      dn = 0;
      for (int j = 0; j < 4; j++) begin
         if (m_pend[j] && j > f) up = 1;
         if (m_pend[j] && j < f) dn = 1;
      end
      if (m_pend[f]) begin
         m_mode = M_DOOR;
         m_left = DOORC;
      end else if (d > 0) begin
         if (up) go(1);
         else if (dn) go(-1);
         else m_mode = M_IDLE;
      end else begin
         if (dn) go(-1);
         else if (up) go(1);
         else m_mode = M_IDLE;
      end
   endtask

   task automatic model_eval();
      logic [3:0] e_nl;
      logic [3:0] np;
      logic       e_load, e_err;
      bit         ok;
      int         f, old_mode;
      ok = ($countones(cur_loc) == 1);
      f = 0;
      for (int i = 0; i < 4; i++) if (cur_loc[i]) f = i;
      e_err  = (m_mode != M_INIT) && !ok;
      e_load = 1'b0;
      e_nl   = m_nl;
      if (m_mode == M_INIT && reset) begin
         e_load = 1'b1;
         e_nl   = 4'b0001;
      end
      if (m_mode == M_TRAVEL && !e_err && m_left == 1) begin
         e_load = 1'b1;
         e_nl   = 4'(1 << (f + m_dir));
      end
      if (m_valid) begin
         chk("load", 4'(load), 4'(e_load));
         chk("next_loc", next_loc, e_nl);
         chk("moving_up", 4'(moving_up), 4'(m_mode == M_TRAVEL && m_dir > 0));
         chk("moving_down", 4'(moving_down), 4'(m_mode == M_TRAVEL && m_dir < 0));
         chk("door_open", 4'(door_open), 4'(m_mode == M_DOOR));
         chk("pending", pending, m_pend);
         chk("loc_err", 4'(loc_err), 4'(e_err));
         if (load === 1'b1) load_log.push_back(next_loc);
      end
      if (door_open === 1'b1) begin
         if (!prev_door) begin
            n_doors++;
            door_floor = cur_loc;
         end
         door_run++;
      end else if (prev_door) begin
         last_door_len = door_run;
         door_run = 0;
         n_falls++;
      end
      prev_door = (door_open === 1'b1);
      if (!reset) begin
         m_valid = 1;
         m_mode  = M_INIT;
         m_pend  = '0;
         m_nl    = 4'b0001;
         m_dir   = 1;
         m_left  = 0;
      end else if (m_valid) begin
         old_mode = m_mode;
         np   = m_pend | req;
         m_nl = e_nl;
         if (e_err) begin
            m_mode = M_INIT;
         end else begin
            case (m_mode)
               M_INIT: m_mode = M_IDLE;
               M_IDLE: begin
                  m_dir = 1;
                  decide(f, 1);
               end
               M_TRAVEL: begin
                  if (m_left == 1) m_mode = M_CHECK;
                  else m_left--;
               end
               M_CHECK: decide(f, m_dir);
               M_DOOR: begin
                  if (m_left == 1) decide(f, m_dir);
                  else m_left--;
               end
               default: m_mode = M_INIT;
            endcase
         end
         if (ok && (old_mode == M_DOOR || m_mode == M_DOOR)) np[f] = 1'b0;
         m_pend = np;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      model_eval();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic pulse_req(input logic [3:0] v);
      req = v;
      tick();
      req = '0;
   endtask

   task automatic wait_rise(input int maxc, output int n);
      int start;
      start = n_doors;
      n = 0;
      while (n_doors == start && n < maxc) begin
         tick();
         n++;
      end
      if (n_doors == start) begin
         n_checks++;
         n_errors++;
         $display("FAIL door_rise_timeout: got none expected rise in %0d", maxc);
      end
   endtask

   task automatic wait_fall(input int maxc);
      int start, n;
      start = n_falls;
      n = 0;
      while (n_falls == start && n < maxc) begin
         tick();
         n++;
      end
      if (n_falls == start) begin
         n_checks++;
         n_errors++;
         $display("FAIL door_fall_timeout: got none expected fall in %0d", maxc);
      end
   endtask

   initial begin
      int n;
      int d0;
      reset     = 1'b0;
      req       = '0;
      force_en  = 1'b0;
      force_val = '0;
      ticks(3);

      // reset release: one INIT load of floor 0
      reset = 1'b1;
      #1;
      chk("init_load", 4'(load), 4'b0001);
      chk("init_next_loc", next_loc, 4'b0001);
      ticks(2);
      chk("parked_q", r_q, 4'b0001);
      chk("idle_status", {moving_up, moving_down, door_open, loc_err}, 4'b0000);

      // floor 0 -> 3 in three legs, one door at the top
      load_log.delete();
      pulse_req(4'b1000);
      wait_rise(80, n);
      chk_i("trip03_ticks", 1 + n, 30);
      chk("trip03_floor", door_floor, 4'b1000);
      chk_i("trip03_loads", load_log.size(), 3);
      if (load_log.size() == 3) begin
         chk("leg1", load_log[0], 4'b0010);
         chk("leg2", load_log[1], 4'b0100);
         chk("leg3", load_log[2], 4'b1000);
      end
      wait_fall(40);
      chk_i("door_len", last_door_len, DOORC);
      chk("trip03_pending", pending, 4'b0000);
      ticks(2);
      chk("trip03_idle", {moving_up, moving_down, door_open, 1'b0}, 4'b0000);

      // back to floor 0, then a stop injected during the first leg
      pulse_req(4'b0001);
      wait_rise(120, n);
      wait_fall(40);
      pulse_req(4'b1000);
      ticks(3);
      pulse_req(4'b0100);
      wait_rise(80, n);
      chk("mid_stop_floor", door_floor, 4'b0100);
      chk("mid_stop_pending", pending, 4'b1000);
      wait_fall(40);
      wait_rise(40, n);
      chk("final_floor", door_floor, 4'b1000);
      wait_fall(40);

      // from floor 2 with calls above and below: up first, then down
      pulse_req(4'b0100);
      wait_rise(40, n);
      wait_fall(40);
      pulse_req(4'b1001);
      wait_rise(40, n);
      chk("both_first", door_floor, 4'b1000);
      wait_fall(40);
      wait_rise(80, n);
      chk("both_second", door_floor, 4'b0001);
      wait_fall(40);
      chk("both_pending", pending, 4'b0000);

      // call for the current floor while the door is open is absorbed
      pulse_req(4'b0001);
      wait_rise(10, n);
      ticks(3);
      pulse_req(4'b0001);
      chk("absorb_pending", pending, 4'b0000);
      wait_fall(40);
      d0 = n_doors;
      ticks(20);
      chk_i("absorb_no_reopen", n_doors, d0);

      // corrupt location: error pulse then reload of floor 0
      force_val = 4'b0110;
      force_en  = 1'b1;
      #1;
      chk("loc_err_pulse", 4'(loc_err), 4'b0001);
      tick();
      force_en = 1'b0;
      #1;
      chk("err_reload", 4'(load), 4'b0001);
      chk("err_reload_loc", next_loc, 4'b0001);
      tick();
      chk("err_q", r_q, 4'b0001);
      chk("err_clear", 4'(loc_err), 4'b0000);
      ticks(2);

      // reset while five cycles into an up leg
      pulse_req(4'b1000);
      ticks(6);
      chk("pre_reset_up", 4'(moving_up), 4'b0001);
      load_log.delete();
      reset = 1'b0;
      ticks(2);
      chk("rst_pending", pending, 4'b0000);
      chk("rst_status", {moving_up, moving_down, door_open, load}, 4'b0000);
      reset = 1'b1;
      #1;
      chk("rst_reload", 4'(load), 4'b0001);
      ticks(2);
      chk("rst_q", r_q, 4'b0001);
      ticks(20);
      chk_i("rst_load_count", load_log.size(), 1);
      if (load_log.size() > 0) chk("rst_load_val", load_log[0], 4'b0001);
      chk("rst_idle", {moving_up, moving_down, door_open, 1'b0}, 4'b0000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/elevator_ctrl.md
Name: elevator_ctrl

Overview:
Elevator motion controller that sits directly upstream of the 4-bit location register. It latches floor call requests and reads the current one-hot location back from the register outputs (Q0..Q3). It drives the register's parallel inputs (P0..P3) and its select S to step the car one floor at a time. It also runs travel and door-dwell timers and reports motion and door status.

Parameters:
NUM_FLOORS, 4, number of floors; fixed at 4 to match the register width; one-hot location encoding.
TRAVEL_CYCLES, 8, clock cycles spent between adjacent floors (minimum 1).
DOOR_CYCLES, 16, clock cycles the door stays open per stop (minimum 1).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-low reset (0 = reset, sampled on the clk rising edge).
req  input  4  floor call requests; bit i = floor i; level or pulse, latched.
cur_loc  input  4  current location, one-hot, wired from register outputs Q3..Q0.
next_loc  output  4  value presented to register inputs P3..P0.
load  output  1  drives register select S; 1 = load next_loc on the next edge.
moving_up  output  1  high while in UP state.
moving_down  output  1  high while in DOWN state.
door_open  output  1  high while in DOOR state.
pending  output  4  latched outstanding requests.
loc_err  output  1  one-cycle pulse when cur_loc is not one-hot outside INIT.

Behaviour:
- Reset (reset=0 at an edge): state=INIT, pending=0, timer=0, load=0, next_loc=4'b0001, all status outputs 0. Reset mid-travel or mid-door abandons the operation; no request survives.
- States: INIT, IDLE, UP, DOWN, CHECK, DOOR.
- INIT: load=1 and next_loc=4'b0001 for exactly one cycle, then IDLE. The register reset value 0 is not a valid location, so the car is parked at floor 0 one edge after INIT.
- Pending: pending |= req every cycle. The bit for the current floor is cleared on the DOOR entry edge. A req for cur_loc that arrives while in DOOR, or on the DOOR entry edge, is absorbed and not latched.
- IDLE:
  - pending & cur_loc != 0 -> DOOR.
  - Otherwise, any pending bit above the current floor -> UP; otherwise any pending bit below -> DOWN; otherwise stay in IDLE.
  - When requests exist both above and below, UP wins.
- UP/DOWN: timer counts 0..TRAVEL_CYCLES-1. At the terminal count, load=1 for one cycle with next_loc = cur_loc<<1 (UP) or cur_loc>>1 (DOWN), then CHECK. next_loc holds its last value when load=0.
- CHECK: runs one cycle after the load edge, so cur_loc is already updated.
  - pending & cur_loc -> DOOR.
  - Else, if requests remain in the same direction, continue in that direction.
  - Else, if requests remain in the opposite direction, reverse.
  - Else IDLE.
- Floor limits: UP is never entered at floor 3 and DOWN is never entered at floor 0. No shift is ever generated off either end.
- DOOR: door_open=1 for DOOR_CYCLES cycles. On exit, apply the CHECK direction rule using the last travel direction; from IDLE the last direction counts as UP.
- Invalid cur_loc (zero or multi-hot) in any state other than INIT: loc_err pulses for one cycle and the FSM goes to INIT to reload floor 0. pending is kept.
- Latency: an idle request at an adjacent floor raises door_open on cycle 2+TRAVEL_CYCLES after it is latched. That count is IDLE decide (1 cycle), TRAVEL_CYCLES, CHECK (1 cycle), then DOOR.
- Exactly one of moving_up, moving_down, door_open is high at a time, or none.

Decomposition:
- Shared package elevator_pkg holds:
  - the state enum;
  - the NUM_FLOORS constant;
  - the one-hot constants FLOOR0..FLOOR3;
  - functions above_mask(loc) and below_mask(loc).
- One sub-module, elev_timer: a loadable down-counter with start and done outputs, instantiated once and shared by travel and door timing.

Test Plan:
- Reset release -> load=1 for one cycle with next_loc=0001; register Q=0001; then IDLE with all status outputs 0.
- Car at floor 0, pulse req=1000 -> three UP legs of TRAVEL_CYCLES each, loads of 0010, 0100, 1000, no intermediate door, then door_open for 16 cycles, pending=0, then IDLE.
- Car at floor 0, req=1000, and req=0100 injected during the first leg -> stop at floor 2 (door), then continue to floor 3.
- Car at floor 2, req=0001 and req=1000 latched in the same cycle -> UP first to floor 3, then reverse DOWN to floor 0; pending empty at the end.
- req=cur_loc while the door is open -> absorbed, no second door cycle; force cur_loc=0110 -> loc_err pulses, INIT reload to 0001.
- Assert reset mid-UP-leg at timer=5 -> outputs reset, pending=0, INIT reload to 0001; no load of the interrupted next floor.
